// File: rtl/alu_regfile_pkg.sv
// Shared constants and ALU operation encoding for the alu_regfile execute core.
package alu_regfile_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREG_LOG2 = 5;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SLTU = 2'b10,
    ALU_RSV  = 2'b11
  } aluop_e;

endpackage

// File: rtl/alu_regfile_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero. Build with REGFILE_BYPASS_EN defined to forward the in-flight
// write data to a matching read port in the same cycle.
module alu_regfile_regfile #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr_en;

  assign w_wr_en = we && (waddr != '0);

  // Storage update: synchronous reset clears every entry and takes priority over a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read ports: x0 forced to zero, optional same-cycle forwarding of the write.
  always_comb begin
    rdata1 = r_mem[raddr1];
    rdata2 = r_mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (raddr1 == waddr)) rdata1 = wdata;
    if (w_wr_en && (raddr2 == waddr)) rdata2 = wdata;
`endif
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/alu_regfile.sv
// Integer execute core: register file plus combinational ALU (pass, add, unsigned compare).
// Optional feature macro REGFILE_BYPASS_EN is handled inside the register file.
module alu_regfile
  import alu_regfile_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] raddr1,
  output logic [XLEN-1:0]         rdata1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata2,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [XLEN-1:0]         src1,
  input  logic [XLEN-1:0]         src2,
  input  logic [1:0]              aluop,
  output logic [XLEN-1:0]         result
);

  aluop_e w_op;

  assign w_op = aluop_e'(aluop);

  alu_regfile_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  // ALU decode; the reserved encoding behaves as add.
  always_comb begin
    result = src2;
    unique case (w_op)
      ALU_PASS: result = src2;
      ALU_ADD:  result = src1 + src2;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < src2)};
      ALU_RSV:  result = src1 + src2;
      default:  result = src2;
    endcase
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: stimulus pushes expected outputs computed from a
// behavioural model; a monitor on the falling edge pops and compares.
module tb_alu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [63:0] rdata1, rdata2, wdata, src1, src2, result;
  logic        we;
  logic [1:0]  aluop;

  alu_regfile dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .src1   (src1),
    .src2   (src2),
    .aluop  (aluop),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] er;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [63:0] ref_read(input logic [4:0] ra, input logic w_en,
                                           input logic [4:0] wa, input logic [63:0] wd);
    if (ra == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (w_en && wa != 5'd0 && wa == ra) return wd;
`endif
    return model[ra];
  endfunction

  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      2'd0:    return b;
      2'd2:    return (a < b) ? 64'd1 : 64'd0;
      default: return a + b;
    endcase
  endfunction

  // One cycle: drive inputs, optionally record expectations, advance past the edge,
  // then apply the architectural effect of that edge to the model.
  task automatic cycle(input string name, input logic chk, input logic rst,
                       input logic w_en, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    rst_n = rst; we = w_en; waddr = wa; wdata = wd;
    raddr1 = ra1; raddr2 = ra2; aluop = op; src1 = a; src2 = b;
    if (chk) begin
      e.name = name;
      e.e1 = ref_read(ra1, w_en, wa, wd);
      e.e2 = ref_read(ra2, w_en, wa, wd);
      e.er = ref_alu(op, a, b);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (w_en && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic rd(input string name, input logic [4:0] ra1, input logic [4:0] ra2);
    cycle(name, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0, ra1, ra2, 2'd0, 64'd0, 64'd0);
  endtask

  task automatic alu(input string name, input logic [1:0] op, input logic [63:0] a,
                     input logic [63:0] b);
    cycle(name, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, op, a, b);
  endtask

  // Monitor: outputs are combinational, so every checked cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (rdata1 !== e.e1) begin
          n_fail++;
          $display("FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.e1);
        end
        n_checks++;
        if (rdata2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.e2);
        end
        n_checks++;
        if (result !== e.er) begin
          n_fail++;
          $display("FAIL %s result: got %h expected %h", e.name, result, e.er);
        end
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    // Initial reset, unchecked (array content is unknown before the first edge).
    cycle("init", 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 2'd0, 64'd0, 64'd0);
    cycle("init", 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 2'd0, 64'd0, 64'd0);
    for (int i = 0; i < 32; i++) rd("reset_state", 5'(i), 5'(31 - i));

    // Reset clears a written register; a write during reset is dropped.
    cycle("wr_x5", 1'b1, 1'b1, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd5, 2'd0, 64'd0, 64'd0);
    rd("x5_written", 5'd5, 5'd5);
    cycle("rst_mid", 1'b1, 1'b0, 1'b1, 5'd3, 64'h77, 5'd5, 5'd3, 2'd1, 64'd3, 64'd4);
    for (int i = 0; i < 32; i++) rd("after_rst", 5'(i), 5'(i ^ 5));

    // x0 ignores writes.
    cycle("wr_x0", 1'b1, 1'b1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 2'd0,
          64'd0, 64'd0);
    rd("x0_read", 5'd0, 5'd0);

    // Write/read on x10: old value before the edge unless forwarding is built in.
    cycle("wr_x10", 1'b1, 1'b1, 1'b1, 5'd10, 64'h1234567887654321, 5'd10, 5'd10, 2'd0,
          64'd0, 64'd0);
    rd("x10_read", 5'd10, 5'd10);

    // Same-cycle read of x7 while it is written.
    cycle("byp_x7", 1'b1, 1'b1, 1'b1, 5'd7, 64'h55, 5'd7, 5'd0, 2'd0, 64'd0, 64'hABCD);
    rd("x7_read", 5'd7, 5'd10);

    // ALU boundary cases.
    alu("add_wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    alu("add_neg", 2'd1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_F000);
    alu("sltu_big", 2'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    alu("sltu_eq", 2'd2, 64'd5, 64'd5);
    alu("seqz", 2'd2, 64'd0, 64'd1);
    alu("pass", 2'd0, 64'h1111, 64'hABCD);
    alu("rsv_add", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      a = {$urandom(), $urandom()};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
      cycle("random", 1'b1, ($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), {$urandom(), $urandom()},
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), a, b);
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Integer execute core for the single-cycle RV64 datapath. It pairs a 32×64-bit architectural register file with a combinational ALU, and sits between instruction decode and writeback/memory in the top level. Register reads and ALU results are combinational. Register writes commit on the rising clock edge.

## Interface
Parameters:
- XLEN, 64: datapath width.
- NREG, 32: number of architectural registers; address width is log2(NREG) = 5.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- raddr1  in  5  read port 1 address.
- rdata1  out  64  read port 1 data, combinational.
- raddr2  in  5  read port 2 address.
- rdata2  out  64  read port 2 data, combinational.
- we  in  1  write enable.
- waddr  in  5  write address.
- wdata  in  64  write data.
- src1  in  64  ALU operand 1.
- src2  in  64  ALU operand 2.
- aluop  in  2  ALU operation select.
- result  out  64  ALU result, combinational.

## Operation
- Register file: NREG entries of XLEN bits, with two asynchronous read ports and one synchronous write port.
- x0 is hardwired to zero:
  - A read of address 0 always returns 0.
  - A write to address 0 is discarded.
- A write occurs at the rising edge when we=1 and waddr≠0: entry[waddr] ← wdata.
- ALU decode, fully combinational:
  - aluop=2'b00: result = src2 (pass-through, used for immediates).
  - aluop=2'b01: result = src1 + src2, modulo 2^64; carry out is dropped.
  - aluop=2'b10: result = {63'b0, (src1 <u src2)}, an unsigned compare (SLTIU/SLTU).
  - aluop=2'b11: reserved; result = src1 + src2.
- Both read ports may address the same register; both return the same value.
- The ALU has no dependency on the register file. Ports are wired externally.

## Timing
- Reset:
  - When rst_n=0 at a rising edge, all NREG entries become 0.
  - A write requested in the same cycle is ignored; reset wins.
  - Reset asserted mid-sequence discards pending state; there is no partial write.
- Read latency is 0 cycles. rdata reflects the current array contents combinationally.
- Write latency is 1 cycle. Data written at edge N is visible on rdata from just after edge N.
- Read-during-write to the same address (no bypass): rdata returns the old value until the edge, then the new value.
- Outputs after reset: rdata1 = rdata2 = 0 for every address. result is a pure function of src1/src2/aluop.
- No handshake; the core accepts new inputs every cycle.

## Configuration
- Macro REGFILE_BYPASS_EN.
- When defined: each read port forwards wdata combinationally if we=1, waddr≠0 and raddrN==waddr. The write is thus visible in the same cycle.
- When undefined: no forwarding; reads return stored contents only.
- x0 reads return 0 in both modes.

## Structure
- Shared package alu_regfile_pkg holds:
  - XLEN and NREG_LOG2 constants.
  - An aluop enum/localparams: ALU_PASS=2'b00, ALU_ADD=2'b01, ALU_SLTU=2'b10, ALU_RSV=2'b11.
- One sub-module, regfile: the storage array, write logic and x0/bypass handling.
- The ALU is an inline combinational case statement in alu_regfile.

## Test plan
- Reset: drive rst_n=0 for 1 cycle after writing 0xDEAD to x5 → rdata1 for x5 reads 0, and all 32 registers read 0.
- x0: write 0xFFFF_FFFF_FFFF_FFFF to x0 with we=1 → rdata1(raddr1=0)=0 next cycle.
- Write/read: write 0x1234567887654321 to x10 → rdata1(raddr1=10) equals it after the edge. rdata2(raddr2=10) matches. Without REGFILE_BYPASS_EN, the value before the edge is the old value (0).
- ADD wrap: aluop=01, src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 → result=1. src1=0x8000_0000, src2=0xFFFF_FFFF_FFFF_F000 (sign-extended -4096) → 0x7FFF_F000.
- SLTU: aluop=10, src1=1, src2=0xFFFF_FFFF_FFFF_FFFF → result=1. src1=5, src2=5 → 0. src1=0, src2=1 (SEQZ) → 1.
- PASS and bypass: aluop=00, src2=0xABCD → result=0xABCD. With REGFILE_BYPASS_EN, we=1, waddr=raddr1=7, wdata=0x55 → rdata1=0x55 in the same cycle.
